// File: rtl/semaforo_pkg.sv
// Shared types for the parametrised traffic-light controller: light states,
// lamp bundle and a small helper used to size the phase counter.
package semaforo_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    GREEN     = 3'd1,
    YELLOW    = 3'd2,
    WALK      = 3'd3,
    FLASH     = 3'd4,
    ALERT_ON  = 3'd5,
    ALERT_OFF = 3'd6
  } light_state_t;

  typedef struct packed {
    logic gc;
    logic yc;
    logic rc;
    logic gp;
    logic rp;
  } lamps_t;

  localparam lamps_t LAMPS_OFF = '0;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Tick-enabled phase counter with synchronous clear and optional saturation
// at SAT_VAL; the parent owns all phase-end comparisons.
module semaforo_timer #(
  parameter int W       = 4,
  parameter int SAT_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         sat,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT_LIM = W'(SAT_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (!(sat && cnt >= SAT_LIM)) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_param.sv
// Car/pedestrian traffic-light controller with parametrised phase lengths,
// latched pedestrian request, optional demand-only green and alert blinking.
module semaforo_param
  import semaforo_pkg::*;
#(
  parameter int GREEN_T     = 6,
  parameter int MIN_GREEN_T = 2,
  parameter int YELLOW_T    = 1,
  parameter int WALK_T      = 4,
  parameter int FLASH_T     = 5,
  parameter int DEMAND      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic a,
  input  logic req,
  output logic gc,
  output logic yc,
  output logic rc,
  output logic gp,
  output logic rp,
  output logic wt
);

  localparam int MAXP = max2(max2(max2(GREEN_T, YELLOW_T), max2(WALK_T, FLASH_T)), MIN_GREEN_T);
  localparam int W    = $clog2(MAXP) + 1;
  localparam bit DEMAND_ON = (DEMAND != 0);

  localparam logic [W-1:0] G_END  = W'(GREEN_T - 1);
  localparam logic [W-1:0] MG_END = W'(MIN_GREEN_T - 1);
  localparam logic [W-1:0] Y_END  = W'(YELLOW_T - 1);
  localparam logic [W-1:0] W_END  = W'(WALK_T - 1);
  localparam logic [W-1:0] F_END  = W'(FLASH_T - 1);

  generate
    if (GREEN_T < 1 || MIN_GREEN_T < 1 || YELLOW_T < 1 || WALK_T < 1 || FLASH_T < 1 ||
        MIN_GREEN_T > GREEN_T || (FLASH_T % 2) == 0) begin : g_bad_params
      $error("semaforo_param: illegal phase-length parameters");
    end
  endgenerate

  light_state_t state;
  light_state_t next_state;
  logic [W-1:0] cnt;
  logic         req_pend;
  logic         leave_green;
  lamps_t       lamps;

  // Demand mode only releases green after the full phase and with a request waiting.
  always_comb begin
    if (DEMAND_ON) leave_green = (cnt >= G_END) && req_pend;
    else           leave_green = (cnt == G_END) || ((cnt >= MG_END) && req_pend);
  end

  always_comb begin
    next_state = state;
    if (a) begin
      next_state = (state == ALERT_ON) ? ALERT_OFF : ALERT_ON;
    end else begin
      case (state)
        OFF:                 next_state = GREEN;
        GREEN:               if (leave_green)   next_state = YELLOW;
        YELLOW:              if (cnt == Y_END)  next_state = WALK;
        WALK:                if (cnt == W_END)  next_state = FLASH;
        FLASH:               if (cnt == F_END)  next_state = GREEN;
        ALERT_ON, ALERT_OFF: next_state = GREEN;
        default:             next_state = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else if (tick) state <= next_state;
  end

  // Request latch runs every clock; a new press wins over the WALK-entry clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pend <= 1'b0;
    end else if (req) begin
      req_pend <= 1'b1;
    end else if (tick && next_state == WALK && state != WALK) begin
      req_pend <= 1'b0;
    end
  end

  semaforo_timer #(
    .W       (W),
    .SAT_VAL (GREEN_T - 1)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (tick),
    .clr (next_state != state),
    .sat (DEMAND_ON && state == GREEN),
    .cnt (cnt)
  );

  always_comb begin
    lamps = LAMPS_OFF;
    case (state)
      GREEN:    begin lamps.gc = 1'b1; lamps.rp = 1'b1; end
      YELLOW:   begin lamps.yc = 1'b1; lamps.rp = 1'b1; end
      WALK:     begin lamps.rc = 1'b1; lamps.gp = 1'b1; end
      FLASH:    begin lamps.rc = 1'b1; lamps.rp = ~cnt[0]; end
      ALERT_ON: lamps.yc = 1'b1;
      default:  lamps = LAMPS_OFF;
    endcase
  end

  assign gc = lamps.gc;
  assign yc = lamps.yc;
  assign rc = lamps.rc;
  assign gp = lamps.gp;
  assign rp = lamps.rp;
  assign wt = req_pend;

endmodule

// File: tb/tb_semaforo_param.sv
// Bench for semaforo_param: a default instance and a demand-mode instance,
// directed stimulus with hand-computed lamp vectors checked by a queue monitor.
module tb_semaforo_param;

  // Lamp vector layout: {gc, yc, rc, gp, rp, wt}
  localparam logic [5:0] L_OFF = 6'b000000;
  localparam logic [5:0] L_G   = 6'b100010;
  localparam logic [5:0] L_Y   = 6'b010010;
  localparam logic [5:0] L_W   = 6'b001100;
  localparam logic [5:0] L_F1  = 6'b001010;
  localparam logic [5:0] L_F0  = 6'b001000;
  localparam logic [5:0] L_A   = 6'b010000;
  localparam logic [5:0] WT    = 6'b000001;

  logic clk = 1'b0;
  logic rst, tick, a, req0, req1, a1;
  logic gc0, yc0, rc0, gp0, rp0, wt0;
  logic gc1, yc1, rc1, gp1, rp1, wt1;

  logic [6:0] exp_q[$];
  string      tag_q[$];
  string      cur_tag = "reset";
  int         n_chk = 0;
  int         n_fail = 0;
  event       chk_ev;

  always #5 clk = ~clk;

  semaforo_param u_dut0 (
    .clk (clk), .rst (rst), .tick (tick), .a (a), .req (req0),
    .gc (gc0), .yc (yc0), .rc (rc0), .gp (gp0), .rp (rp0), .wt (wt0)
  );

  semaforo_param #(.DEMAND(1)) u_dut1 (
    .clk (clk), .rst (rst), .tick (tick), .a (a1), .req (req1),
    .gc (gc1), .yc (yc1), .rc (rc1), .gp (gp1), .rp (rp1), .wt (wt1)
  );

  function automatic void push(input logic sel, input logic [5:0] e);
    exp_q.push_back({sel, e});
    tag_q.push_back(cur_tag);
  endfunction

  // Drive one clock of inputs, then queue the outputs expected after that edge.
  task automatic cyc(input logic t, input logic aa, input logic r, input logic sel,
                     input logic [5:0] e);
    tick = t;
    a    = aa;
    if (sel) req1 = r;
    else     req0 = r;
    @(posedge clk);
    #1;
    push(sel, e);
  endtask

  // Four clocks with a single tick on the first one.
  task automatic grp(input logic [5:0] e);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, e);
    for (int j = 1; j < 4; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic base_cycle();
    push(1'b0, L_OFF);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, L_G);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_Y);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, L_W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_G);
  endtask

  // Monitor: drains every pending expectation at the sampling point.
  initial begin
    logic [6:0] e;
    logic [5:0] act;
    string      tg;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        tg  = tag_q.pop_front();
        act = e[6] ? {gc1, yc1, rc1, gp1, rp1, wt1} : {gc0, yc0, rc0, gp0, rp0, wt0};
        n_chk++;
        if (act !== e[5:0]) begin
          n_fail++;
          $display("FAIL %s dut%0d at %0t: lamps got %b expected %b", tg, e[6], $time, act, e[5:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; tick = 1'b0; a = 1'b0; a1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    push(1'b0, L_OFF);
    @(posedge clk); #1;
    push(1'b1, L_OFF);
    @(posedge clk); #1;
    rst = 1'b0;

    cur_tag = "demand_hold";
    push(1'b1, L_OFF);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, L_G);
    cur_tag = "demand_req";
    cyc(1'b1, 1'b0, 1'b1, 1'b1, L_G | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, L_Y | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, L_W);

    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_tag = "base";
    base_cycle();

    cur_tag = "req_early";
    cyc(1'b1, 1'b0, 1'b1, 1'b0, L_G | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_Y | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_W);

    cur_tag = "alert";
    cyc(1'b1, 1'b1, 1'b1, 1'b0, L_A | WT);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, L_OFF | WT);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, L_A | WT);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, L_OFF | WT);
    cur_tag = "alert_exit";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_G | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_G | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_Y | WT);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, L_W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_F0);

    cur_tag = "slow_tick";
    grp(L_F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_G);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, L_G | WT);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, L_G | WT);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, L_G | WT);
    grp(L_G | WT);
    grp(L_Y | WT);
    for (int i = 0; i < 4; i++) grp(L_W);
    grp(L_F1); grp(L_F0); grp(L_F1); grp(L_F0); grp(L_F1);
    grp(L_G);

    cur_tag = "async_rst";
    cyc(1'b1, 1'b0, 1'b1, 1'b0, L_G | WT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, L_Y | WT);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    push(1'b0, L_OFF);
    -> chk_ev;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_tag = "restart";
    base_cycle();

    @(negedge clk); #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
